// File: rtl/ft_recovery_sequencer.sv
// ---------------------------------------------------------------------------
// ft_recovery_sequencer
//
// Rollback restore engine for the fault-tolerance controller. On a rising
// edge of recover_i it reads architectural registers x1..x(NUM_REGS-1) and
// then the saved PC from the safe memory. Each register word is written into
// the cores' register-file restore port, and the PC goes to the PC load port.
// Completion is reported with a one-cycle done_o. A read error or a
// handshake that stalls too long ends the sequence in a sticky failure.
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   recover_i      recover request level; a sequence starts on its rising edge
//   data_req_o     safe-memory read request, held until data_gnt_i
//   data_gnt_i     request accepted
//   data_rvalid_i  read data valid
//   data_addr_o    read byte address (BASE_ADDR + 4*slot, wraps modulo 2^32)
//   data_rdata_i   read data
//   data_err_i     read error, qualified by data_rvalid_i
//   rf_we_o        register restore write strobe (1-cycle pulse)
//   rf_addr_o      restore register index, 0 when rf_we_o is 0
//   rf_wdata_o     restore data, 0 when rf_we_o is 0
//   pc_we_o        PC load strobe (1-cycle pulse)
//   pc_o           restored PC, 0 when pc_we_o is 0
//   busy_o         sequence in progress (every state except IDLE and FAIL)
//   done_o         recovery-done pulse (1 cycle)
//   fail_o         sticky failure flag, cleared by the next start
// ---------------------------------------------------------------------------
module ft_recovery_sequencer #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  recover_i,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [31:0]           data_addr_o,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  pc_we_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o
);

    // Register index counts 1..NUM_REGS-1; timer counts 0..TIMEOUT-1.
    localparam int unsigned IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    // The saved PC lives in the slot right after the last register slot.
    localparam logic [31:0]      PC_ADDR  = BASE_ADDR + 32'(NUM_REGS) * 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [TMR_W-1:0] r_timer;
    logic             r_pc_phase;
    logic             r_recover_q;

    logic             w_start;
    logic             w_timeout;
    logic             w_last_reg;
    logic [IDX_W-1:0] w_next_idx;

    // Byte address of a register slot; plain 32-bit arithmetic, wraps silently.
    function automatic logic [31:0] slot_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + (32'(idx) << 2);
    endfunction

    assign w_start    = recover_i & ~r_recover_q;
    assign w_timeout  = (r_timer == TMR_LAST);
    assign w_last_reg = (r_idx == LAST_IDX);
    assign w_next_idx = r_idx + IDX_W'(1);

    // All outputs are registers computed together with the next state, so
    // each output value belongs to the state the FSM is entering.
    always_ff @(posedge clk_i) begin
        // NOTE: rst_ni is sampled only at the clock edge here; a reset pulse
        // that never overlaps a rising edge of clk_i has no effect.
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_idx       <= IDX_W'(1);
            r_timer     <= '0;
            r_pc_phase  <= 1'b0;
            r_recover_q <= 1'b0;
            data_req_o  <= 1'b0;
            data_addr_o <= '0;
            rf_we_o     <= 1'b0;
            rf_addr_o   <= '0;
            rf_wdata_o  <= '0;
            pc_we_o     <= 1'b0;
            pc_o        <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            fail_o      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below
            // are overridden by later assignments in the same cycle, and
            // every read sees the pre-edge value of each register.
            r_recover_q <= recover_i;

            // Strobes and their qualified buses fall back to zero each cycle.
            rf_we_o    <= 1'b0;
            rf_addr_o  <= '0;
            rf_wdata_o <= '0;
            pc_we_o    <= 1'b0;
            pc_o       <= '0;
            done_o     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_REQ;
                        r_idx       <= IDX_W'(1);
                        r_pc_phase  <= 1'b0;
                        r_timer     <= '0;
                        fail_o      <= 1'b0;
                        busy_o      <= 1'b1;
                        data_req_o  <= 1'b1;
                        data_addr_o <= slot_addr(IDX_W'(1));
                    end
                end

                // Address stays untouched while waiting for the grant; a
                // stray rvalid here is not looked at.
                S_REQ: begin
                    if (data_gnt_i) begin
                        r_state     <= S_WAIT;
                        r_timer     <= '0;
                        data_req_o  <= 1'b0;
                        data_addr_o <= '0;
                    end else if (w_timeout) begin
                        r_state     <= S_FAIL;
                        fail_o      <= 1'b1;
                        busy_o      <= 1'b0;
                        data_req_o  <= 1'b0;
                        data_addr_o <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                // The read word is captured straight into the strobe-qualified
                // output register used in the following WRITE cycle.
                S_WAIT: begin
                    if (data_rvalid_i && data_err_i) begin
                        r_state <= S_FAIL;
                        fail_o  <= 1'b1;
                        busy_o  <= 1'b0;
                    end else if (data_rvalid_i) begin
                        r_state <= S_WRITE;
                        if (r_pc_phase) begin
                            pc_we_o <= 1'b1;
                            pc_o    <= DATA_WIDTH'(data_rdata_i);
                        end else begin
                            rf_we_o    <= 1'b1;
                            rf_addr_o  <= ADDR_WIDTH'(r_idx);
                            rf_wdata_o <= DATA_WIDTH'(data_rdata_i);
                        end
                    end else if (w_timeout) begin
                        r_state <= S_FAIL;
                        fail_o  <= 1'b1;
                        busy_o  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                S_WRITE: begin
                    if (r_pc_phase) begin
                        r_state <= S_DONE;
                        done_o  <= 1'b1;
                    end else begin
                        r_state    <= S_REQ;
                        r_timer    <= '0;
                        data_req_o <= 1'b1;
                        if (w_last_reg) begin
                            r_pc_phase  <= 1'b1;
                            data_addr_o <= PC_ADDR;
                        end else begin
                            r_idx       <= w_next_idx;
                            data_addr_o <= slot_addr(w_next_idx);
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    busy_o  <= 1'b0;
                end

                // fail_o is left set; only the next start clears it.
                S_FAIL: begin
                    if (!recover_i) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    busy_o     <= 1'b0;
                    data_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
